// File: rtl/irq_cond.sv
// irq_cond: interrupt request conditioner placed directly upstream of pic.
// Each line is synchronized and optionally debounced. It is then presented on IR
// either as a level or as a latched rising-edge request that pic clears.
// A sticky per-line overrun flag records edges lost while a request was pending.
// Optional debounce filter: define IRQ_COND_FILTER_EN to compile it in.

module irq_cond_lane #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic mode,
    input  logic clear,
    output logic req,
    output logic ovr
);
    // Elaboration-time sanity checks on the lane configuration.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("irq_cond: SYNC_STAGES must be at least 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("irq_cond: FILTER_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   f;
    logic                   prev;
    logic                   rise;
    logic                   pending;
    logic                   pending_next;
    logic                   ovr_next;

    // Synchronizer chain for the asynchronous raw line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], irq};
    end

    assign s = sync[SYNC_STAGES-1];

`ifdef IRQ_COND_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Debounce: f follows s only after FILTER_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            f   <= 1'b0;
        end else if (s == f) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            f   <= s;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign f = s;
`endif

    // prev restarts at 0 after reset, so a line already high gives one edge.
    assign rise = f & ~prev;

    // Request/overrun next state; a rise wins over a simultaneous clear.
    always_comb begin
        pending_next = 1'b0;
        ovr_next     = ovr & ~clear;
        if (mode) begin
            pending_next = rise | (pending & ~clear);
            if (rise && pending && !clear) ovr_next = 1'b1;
        end
    end

    // Edge history, latched request, overrun flag and registered IR output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev    <= 1'b0;
            pending <= 1'b0;
            ovr     <= 1'b0;
            req     <= 1'b0;
        end else begin
            prev    <= f;
            pending <= pending_next;
            ovr     <= ovr_next;
            req     <= mode ? pending_next : f;
        end
    end
endmodule

module irq_cond #(
    parameter int NUM_IRQ       = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] edge_mode,
    input  logic [NUM_IRQ-1:0] ir_clear,
    output logic [NUM_IRQ-1:0] IR,
    output logic [NUM_IRQ-1:0] overrun
);
    // Lanes are identical and fully independent.
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_lane
        irq_cond_lane #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .irq   (irq_in[i]),
            .mode  (edge_mode[i]),
            .clear (ir_clear[i]),
            .req   (IR[i]),
            .ovr   (overrun[i])
        );
    end
endmodule

// File: tb/tb_irq_cond.sv
// Self-checking bench for irq_cond with default parameters.
// Expected IR/overrun values are queued per cycle when stimulus is driven.
// They are popped and compared one clock later.
module tb_irq_cond;
`ifdef IRQ_COND_FILTER_EN
    localparam bit FILT = 1'b1;
    localparam int LAT  = 7;
`else
    localparam bit FILT = 1'b0;
    localparam int LAT  = 3;
`endif

    typedef struct packed {
        logic [7:0] ir;
        logic [7:0] ovr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic [7:0] edge_mode;
    logic [7:0] ir_clear;
    logic [7:0] IR;
    logic [7:0] overrun;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    irq_cond dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .edge_mode (edge_mode),
        .ir_clear  (ir_clear),
        .IR        (IR),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Drop all lines, let the filter settle, and clear everything.
    task automatic cleanup();
        irq_in = 8'h00;
        idle(LAT + 6);
        ir_clear = 8'hFF;
        tick();
        ir_clear = 8'h00;
        idle(2);
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b0; irq_in = 8'hFF; edge_mode = 8'hFF; ir_clear = 8'h00;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(exp_t'{ir: 8'h00, ovr: 8'h00});
            tick();
            e = sb.pop_front(); vectors++;
            if ({IR, overrun} !== {e.ir, e.ovr}) begin
                miscompares++;
                $display("FAIL reset_hold k=%0d IR=%h ovr=%h exp IR=%h ovr=%h", k, IR, overrun, e.ir, e.ovr);
            end
        end
        reset = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            sb.push_back(exp_t'{ir: (k >= LAT) ? 8'hFF : 8'h00, ovr: 8'h00});
            tick();
            e = sb.pop_front(); vectors++;
            if ({IR, overrun} !== {e.ir, e.ovr}) begin
                miscompares++;
                $display("FAIL reset_release k=%0d IR=%h ovr=%h exp IR=%h ovr=%h", k, IR, overrun, e.ir, e.ovr);
            end
        end
        cleanup();
    endtask

    task automatic test_edge_latch();
        exp_t e;
        edge_mode = 8'h08; irq_in = 8'h08;
        for (int k = 1; k <= 16; k++) begin
            sb.push_back(exp_t'{ir: (k >= LAT) ? 8'h08 : 8'h00, ovr: 8'h00});
            tick();
            e = sb.pop_front(); vectors++;
            if ({IR, overrun} !== {e.ir, e.ovr}) begin
                miscompares++;
                $display("FAIL edge_latch k=%0d IR=%h ovr=%h exp IR=%h ovr=%h", k, IR, overrun, e.ir, e.ovr);
            end
            if (k == 10) irq_in = 8'h00;
        end
        ir_clear = 8'h08;
        for (int k = 1; k <= 2; k++) begin
            sb.push_back(exp_t'{ir: 8'h00, ovr: 8'h00});
            tick();
            ir_clear = 8'h00;
            e = sb.pop_front(); vectors++;
            if ({IR, overrun} !== {e.ir, e.ovr}) begin
                miscompares++;
                $display("FAIL edge_clear k=%0d IR=%h ovr=%h exp IR=%h ovr=%h", k, IR, overrun, e.ir, e.ovr);
            end
        end
        cleanup();
    endtask

    // Phases: 0 first request, 1 lost edge sets overrun, 2 fresh request,
    // 3 clear coinciding with the rise keeps the request and no overrun.
    task automatic test_overrun();
        exp_t e;
        edge_mode = 8'hFF;
        for (int p = 0; p < 4; p++) begin
            irq_in = 8'h20;
            for (int k = 1; k <= 18; k++) begin
                sb.push_back(exp_t'{
                    ir:  (p == 1 || p == 3 || k >= LAT) ? 8'h20 : 8'h00,
                    ovr: (p == 1 && k >= LAT) ? 8'h20 : 8'h00});
                tick();
                ir_clear = (p == 3 && k == LAT - 1) ? 8'h20 : 8'h00;
                e = sb.pop_front(); vectors++;
                if ({IR, overrun} !== {e.ir, e.ovr}) begin
                    miscompares++;
                    $display("FAIL overrun p=%0d k=%0d IR=%h ovr=%h exp IR=%h ovr=%h", p, k, IR, overrun, e.ir, e.ovr);
                end
                if (k == 6) irq_in = 8'h00;
            end
            if (p == 1) begin
                ir_clear = 8'h20;
                sb.push_back(exp_t'{ir: 8'h00, ovr: 8'h00});
                tick();
                ir_clear = 8'h00;
                e = sb.pop_front(); vectors++;
                if ({IR, overrun} !== {e.ir, e.ovr}) begin
                    miscompares++;
                    $display("FAIL overrun_clear IR=%h ovr=%h exp IR=%h ovr=%h", IR, overrun, e.ir, e.ovr);
                end
            end
        end
        cleanup();
    endtask

    // Pulses of 3 and 4 clocks on line 0, then a 1-clock pulse on line 7.
    task automatic test_glitch();
        exp_t e;
        int   len;
        int   line;
        logic pass;
        edge_mode = 8'hFF;
        for (int p = 0; p < 3; p++) begin
            len  = (p == 0) ? 3 : (p == 1) ? 4 : 1;
            line = (p == 2) ? 7 : 0;
            pass = (p == 1) || !FILT;
            irq_in = 8'h00;
            irq_in[line] = 1'b1;
            for (int k = 1; k <= 14; k++) begin
                sb.push_back(exp_t'{ir: (pass && k >= LAT) ? (8'h01 << line) : 8'h00, ovr: 8'h00});
                tick();
                e = sb.pop_front(); vectors++;
                if ({IR, overrun} !== {e.ir, e.ovr}) begin
                    miscompares++;
                    $display("FAIL glitch len=%0d k=%0d IR=%h ovr=%h exp IR=%h ovr=%h", len, k, IR, overrun, e.ir, e.ovr);
                end
                if (k == len) irq_in = 8'h00;
            end
            cleanup();
        end
    endtask

    task automatic test_level();
        exp_t e;
        edge_mode = 8'h00; irq_in = 8'h02;
        for (int k = 1; k <= 32; k++) begin
            sb.push_back(exp_t'{ir: (k >= LAT && k < LAT + 20) ? 8'h02 : 8'h00, ovr: 8'h00});
            tick();
            ir_clear = (k == 10) ? 8'h02 : 8'h00;
            e = sb.pop_front(); vectors++;
            if ({IR, overrun} !== {e.ir, e.ovr}) begin
                miscompares++;
                $display("FAIL level k=%0d IR=%h ovr=%h exp IR=%h ovr=%h", k, IR, overrun, e.ir, e.ovr);
            end
            if (k == 20) irq_in = 8'h00;
        end
        cleanup();
    endtask

    // Edge->level drops a pending request; level->edge with f=1 makes no request.
    task automatic test_mode_change();
        exp_t e;
        edge_mode = 8'hFF; irq_in = 8'h10;
        idle(2);
        irq_in = 8'h00;
        idle(LAT + 8);
        edge_mode = 8'h00;
        sb.push_back(exp_t'{ir: 8'h00, ovr: 8'h00});
        tick();
        e = sb.pop_front(); vectors++;
        if ({IR, overrun} !== {e.ir, e.ovr}) begin
            miscompares++;
            $display("FAIL mode_edge2level IR=%h ovr=%h exp IR=%h ovr=%h", IR, overrun, e.ir, e.ovr);
        end
        irq_in = 8'h10;
        idle(LAT + 2);
        sb.push_back(exp_t'{ir: 8'h10, ovr: 8'h00});
        e = sb.pop_front(); vectors++;
        if ({IR, overrun} !== {e.ir, e.ovr}) begin
            miscompares++;
            $display("FAIL mode_level_high IR=%h ovr=%h exp IR=%h ovr=%h", IR, overrun, e.ir, e.ovr);
        end
        edge_mode = 8'hFF;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(exp_t'{ir: 8'h00, ovr: 8'h00});
            tick();
            e = sb.pop_front(); vectors++;
            if ({IR, overrun} !== {e.ir, e.ovr}) begin
                miscompares++;
                $display("FAIL mode_level2edge k=%0d IR=%h ovr=%h exp IR=%h ovr=%h", k, IR, overrun, e.ir, e.ovr);
            end
        end
        cleanup();
    endtask

    // Reset mid-cycle drops outputs at once; a held line re-requests after release.
    task automatic test_mid_reset();
        exp_t e;
        edge_mode = 8'hFF; irq_in = 8'h24;
        idle(2);
        irq_in = 8'h04;
        idle(12);
        irq_in = 8'h24;
        idle(LAT + 2);
        irq_in = 8'h04;
        #3;
        reset = 1'b0;
        #1;
        sb.push_back(exp_t'{ir: 8'h00, ovr: 8'h00});
        e = sb.pop_front(); vectors++;
        if ({IR, overrun} !== {e.ir, e.ovr}) begin
            miscompares++;
            $display("FAIL mid_reset_async IR=%h ovr=%h exp IR=%h ovr=%h", IR, overrun, e.ir, e.ovr);
        end
        tick();
        reset = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            sb.push_back(exp_t'{ir: (k >= LAT) ? 8'h04 : 8'h00, ovr: 8'h00});
            tick();
            e = sb.pop_front(); vectors++;
            if ({IR, overrun} !== {e.ir, e.ovr}) begin
                miscompares++;
                $display("FAIL mid_reset_release k=%0d IR=%h ovr=%h exp IR=%h ovr=%h", k, IR, overrun, e.ir, e.ovr);
            end
        end
        cleanup();
    endtask

    initial begin
        test_reset();
        test_edge_latch();
        test_overrun();
        test_glitch();
        test_level();
        test_mode_change();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
